demux_1_to_4_stream: RTL and testbench



---
 rtl/demux_pkg.sv | 11 +
 rtl/demux_1_to_4_stream_if.sv | 28 ++
 rtl/demux_slot.sv | 37 +++
 rtl/demux_1_to_4_stream.sv | 77 +++++++
 tb/tb_demux_1_to_4_stream.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int N_CH       = 4;
  localparam int SEL_W      = 2;
  localparam int CNT_W_DEF  = 16;

  typedef logic [SEL_W-1:0] ch_sel_t;

endpackage

// File: rtl/demux_1_to_4_stream_if.sv
// Stream bundle for demux_1_to_4_stream: one input stream in, four channel streams out.
interface demux_1_to_4_stream_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  ch_sel_t                in_sel;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        out_ready;
  logic [N_CH*DATA_W-1:0] out_data;

  // Environment side: produces the input stream and consumes the channels.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
module demux_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;

  // Push wins over pop so a same-cycle refill keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else if (push) begin
      valid_r <= 1'b1;
      data_r  <= push_data;
    end else if (pop) begin
      valid_r <= 1'b0;
      data_r  <= data_r;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/demux_1_to_4_stream.sv
// Routes one stream to four independently handshaked channels.
// Optional per-channel saturating accept counters under `define DEMUX_STATS_EN.
module demux_1_to_4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux_1_to_4_stream_if.slave   bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [N_CH*CNT_W-1:0]  stat_cnt
`endif
);

  ch_sel_t                sel_s;
  logic                   in_ready_s;
  logic                   accept_s;
  logic [N_CH-1:0]        push_s;
  logic [N_CH-1:0]        pop_s;
  logic [N_CH-1:0]        valid_s;
  logic [N_CH*DATA_W-1:0] data_s;

  // A full slot can still accept when its consumer drains it this cycle.
  assign sel_s      = bus.in_sel;
  assign in_ready_s = !valid_s[sel_s] || bus.out_ready[sel_s];
  assign accept_s   = bus.in_valid && in_ready_s;
  assign pop_s      = valid_s & bus.out_ready;

  // One-hot push decode of the accepted word's destination.
  always_comb begin
    push_s = {N_CH{1'b0}};
    if (accept_s) begin
      push_s[sel_s] = 1'b1;
    end else begin
      push_s = {N_CH{1'b0}};
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s[gi]),
      .pop       (pop_s[gi]),
      .push_data (bus.in_data),
      .valid     (valid_s[gi]),
      .data      (data_s[gi*DATA_W +: DATA_W])
    );
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_s;
  assign bus.out_data  = data_s;

`ifdef DEMUX_STATS_EN
  for (genvar gc = 0; gc < N_CH; gc++) begin : g_stat
    logic [CNT_W-1:0] cnt_r;

    // Saturating count of words accepted for this channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (push_s[gc] && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign stat_cnt[gc*CNT_W +: CNT_W] = cnt_r;
  end
`endif

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Self-checking bench for demux_1_to_4_stream against a queue-based channel model.
module tb_demux_1_to_4_stream;

`ifdef DEMUX_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int DW = 32;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  demux_1_to_4_stream_if #(.DATA_W(DW)) bus ();

`ifdef DEMUX_STATS_EN
  logic [4*CNT_W-1:0] stat_cnt;
`endif

  demux_1_to_4_stream #(.DATA_W(DW), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef DEMUX_STATS_EN
    ,
    .stat_cnt (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each channel is a queue of words held by the block (depth 1 by design).
  logic [DW-1:0] mq [4][$];
  int            mcnt [4];
  int            npop [4];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mcnt[i] = 0;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_v;
    for (int i = 0; i < 4; i++) exp_v[i] = (mq[i].size() != 0);
    check("out_valid", {124'd0, bus.out_valid}, {124'd0, exp_v});
    for (int i = 0; i < 4; i++) begin
      if (mq[i].size() != 0)
        check($sformatf("out_data%0d", i), {96'd0, bus.out_data[i*DW +: DW]}, {96'd0, mq[i][0]});
    end
`ifdef DEMUX_STATS_EN
    for (int i = 0; i < 4; i++)
      check($sformatf("stat_cnt%0d", i), {{(128-CNT_W){1'b0}}, stat_cnt[i*CNT_W +: CNT_W]}, 128'(mcnt[i]));
`endif
  endtask

  // One clock: drive at negedge, check ready, account pops/pushes, check outputs at next negedge.
  task automatic step(input logic v, input logic [1:0] s, input logic [DW-1:0] d, input logic [3:0] r,
                      output logic acc);
    logic exp_ready;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    exp_ready = (mq[s].size() == 0) || r[s];
    check("in_ready", {127'd0, bus.in_ready}, {127'd0, exp_ready});
    acc = v && exp_ready;
    for (int i = 0; i < 4; i++) begin
      if (mq[i].size() != 0 && r[i]) begin
        void'(mq[i].pop_front());
        npop[i]++;
      end
    end
    if (acc) begin
      mq[s].push_back(d);
      if (mcnt[s] < CMAX) mcnt[s]++;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic          acc;
    logic          pv, ps_hold;
    logic [1:0]    ps;
    logic [DW-1:0] pd;
    int            got [4];
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    for (int i = 0; i < 4; i++) npop[i] = 0;

    // Reset with a push already pending.
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd2;
    bus.in_data   = 32'hDEADBEEF;
    bus.out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {124'd0, bus.out_valid}, 128'h0);
    check("rst_out_data", {bus.out_data}, 128'h0);
    check("rst_in_ready", {127'd0, bus.in_ready}, 128'h1);
    rst_n = 1'b1;
    step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, acc);
    check("first_push_valid", {124'd0, bus.out_valid}, 128'h4);
    check("first_push_data", {96'd0, bus.out_data[2*DW +: DW]}, 128'hDEADBEEF);

    // Full-slot stall, then another channel proceeds.
    step(1'b1, 2'd2, 32'h11111111, 4'b0000, acc);
    check("stall_acc", {127'd0, acc}, 128'h0);
    step(1'b1, 2'd0, 32'h22222222, 4'b0000, acc);
    check("ch0_load", {96'd0, bus.out_data[0 +: DW]}, 128'h22222222);

    // Simultaneous pop and push on channel 1.
    step(1'b1, 2'd1, 32'hA5A5A5A5, 4'b0000, acc);
    step(1'b1, 2'd1, 32'h5A5A5A5A, 4'b0010, acc);
    check("popush_valid1", {127'd0, bus.out_valid[1]}, 128'h1);
    check("popush_data1", {96'd0, bus.out_data[DW +: DW]}, 128'h5A5A5A5A);

    // Drain, then stream 16 round-robin words at full rate.
    step(1'b0, 2'd0, 32'h0, 4'b1111, acc);
    for (int i = 0; i < 4; i++) npop[i] = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 2'(k % 4), DW'(k), 4'b1111, acc);
      check("stream_acc", {127'd0, acc}, 128'h1);
      check("stream_data", {96'd0, bus.out_data[(k%4)*DW +: DW]}, 128'(k));
    end
    step(1'b0, 2'd0, 32'h0, 4'b1111, acc);
    for (int i = 0; i < 4; i++) check($sformatf("stream_cnt%0d", i), 128'(npop[i]), 128'd4);

    // Fill all slots, then reset between clock edges.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 32'hC0DE0000 + DW'(i), 4'b0000, acc);
    check("fill_all", {124'd0, bus.out_valid}, 128'hF);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {124'd0, bus.out_valid}, 128'h0);
    check("async_rst_data", {bus.out_data}, 128'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DEMUX_STATS_EN
    for (int k = 0; k < 20; k++) step(1'b1, 2'd3, DW'(k + 100), 4'b1000, acc);
    check("stat_sat3", {{(128-CNT_W){1'b0}}, stat_cnt[3*CNT_W +: CNT_W]}, 128'hF);
    check("stat_others", {{(128-3*CNT_W){1'b0}}, stat_cnt[0 +: 3*CNT_W]}, 128'h0);
`endif

    // Randomized traffic; a stalled word is held stable until accepted.
    pv = 1'b0;
    ps = 2'd0;
    pd = 32'h0;
    for (int n = 0; n < 400; n++) begin
      ps_hold = pv && !acc;
      if (!ps_hold) begin
        pv = ($urandom % 4) != 0;
        ps = 2'($urandom % 4);
        pd = $urandom;
      end
      step(pv, ps, pd, 4'($urandom % 16), acc);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'h0, 4'b1111, acc);
    for (int i = 0; i < 4; i++) got[i] = mq[i].size();
    check("drained", {got[0][7:0], got[1][7:0], got[2][7:0], got[3][7:0]}, 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
